mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle datapath's memory port. It takes the datapath's 13-bit address, 8-bit write data and MEM_read/MEM_write strobes, and drives a variable-latency external memory over a req/ack handshake.
- It raises busy so the controller stalls until the access completes.
- It holds a one-entry last-read buffer, so a repeated fetch of the same address completes without a memory transaction.
- It enforces a wait timeout and flags an error on expiry.

Parameters:
- ADDR_W, 13, address width (PC/TR width).
- DATA_W, 8, data width.
- TIMEOUT, 15, maximum cycles spent in REQ without ack before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  access address from the datapath address mux.
- cpu_wdata  in  DATA_W  write data (register file reg2).
- cpu_read  in  1  read request (MEM_read).
- cpu_write  in  1  write request (MEM_write).
- cpu_rdata  out  DATA_W  read data to IR/TR inputs; holds the last read value.
- cpu_busy  out  1  access in progress; the controller must hold its state.
- cpu_done  out  1  one-cycle pulse when the access completes.
- cpu_err  out  1  one-cycle pulse, coincident with cpu_done, on timeout.
- mem_req  out  1  external request, level.
- mem_we  out  1  external write enable; valid while mem_req is high.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  external read data; valid when mem_ack is high.
- mem_ack  in  1  external completion; one cycle.

Behaviour:
- Reset (rst low, async): state IDLE.
  - Outputs: cpu_rdata=0, cpu_busy=0, cpu_done=0, cpu_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal: buffer valid=0, timer=0.
  - Reset mid-access drops mem_req immediately. A later ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE, request sampled at edge k:
  - Request means cpu_read|cpu_write. If both are high, the access is a write.
  - Read hit (valid and buf_addr==cpu_addr): go DONE. cpu_rdata<=buf_data, so cpu_done=1 in cycle k+1. No mem_req is issued.
  - Miss or write: latch mem_addr, mem_wdata and mem_we; clear timer; go REQ. mem_req=1 from cycle k+1.
- cpu_busy is combinational: 1 when a request is present in IDLE, and 1 in REQ. It is 0 in DONE.
- REQ:
  - mem_req=1 and the timer increments every cycle.
  - mem_ack high at an edge, read: cpu_rdata<=mem_rdata; buf_addr<=mem_addr; buf_data<=mem_rdata; valid<=1; go DONE.
  - mem_ack high at an edge, write: if valid and buf_addr==mem_addr, buf_data<=mem_wdata (write-through update). Go DONE.
  - Timeout: when the timer reaches TIMEOUT with no ack, go DONE with the error flag set. cpu_rdata is unchanged and the buffer is unchanged.
  - Ack takes priority over timeout on the same edge.
- DONE (exactly one cycle):
  - cpu_done=1; cpu_err=1 if aborted; mem_req=0.
  - Next state is IDLE unconditionally. Requests present during DONE are ignored; the controller deasserts its strobes on cpu_done.
  - A stray mem_ack in IDLE or DONE has no effect.
- Latency: hit = 1 cycle; miss = 2 + ack wait cycles; timeout = TIMEOUT + 2 cycles.
- Timer width: clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package mau_pkg holds:
  - ADDR_W and DATA_W defaults.
  - typedef enum logic [1:0] mau_state_t {IDLE, REQ, DONE}.
- One sub-module, wait_timer: clear/enable saturating counter with an expired output. Parameterised by TIMEOUT; uses the same async active-low rst.

Test Plan:
- Reset mid-REQ: assert rst low while mem_req=1, then ack 2 cycles later → all outputs 0, no cpu_done, state IDLE.
- Read miss: addr=0x0A5, mem_ack after 3 cycles with mem_rdata=0x3C → mem_req high for 4 cycles, cpu_done with cpu_rdata=0x3C, cpu_err=0.
- Read hit: repeat the read of 0x0A5 → cpu_done next cycle, rdata=0x3C, mem_req never asserted.
- Write-through: write 0x77 to 0x0A5 (acked), then read 0x0A5 → write issues mem_we=1; the read is a hit returning 0x77.
- Timeout with TIMEOUT=4: read 0x100 with no ack → cpu_done and cpu_err pulse together, rdata unchanged; an ack arriving afterwards is ignored.
- Simultaneous strobes: cpu_read=cpu_write=1, addr 0x001, wdata 0x5A → mem_we=1 and mem_wdata=0x5A on the bus. A same-edge ack and timer expiry → no cpu_err.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: default bus widths and
// the access state encoding used by the top level.
package mau_pkg;

  localparam int MAU_ADDR_W = 13;
  localparam int MAU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter for the memory handshake. It is cleared while the
// unit is idle, counts every cycle a request is outstanding, and reports
// expiry once the count reaches TIMEOUT. It never wraps.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until the limit and hold there.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit between the multicycle datapath and a variable-latency
// external memory. Converts MEM_read/MEM_write strobes into a req/ack
// transaction, stalls the controller with cpu_busy, short-circuits repeated
// reads of the same address through a one-entry buffer, and aborts an access
// that waits longer than TIMEOUT cycles for an ack.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = MAU_ADDR_W,
  parameter int DATA_W  = MAU_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mau_state_t        state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic cpu_req;
  logic read_hit;
  logic expired;

  // A simultaneous read and write strobe is treated as a write, so only a
  // pure read may be served from the buffer.
  assign cpu_req  = cpu_read | cpu_write;
  assign read_hit = cpu_read && !cpu_write && valid_q && (buf_addr_q == cpu_addr);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == IDLE),
    .en_i      (state_q == REQ),
    .expired_o (expired)
  );

  // Next-state and datapath updates for the IDLE -> REQ -> DONE access cycle.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (cpu_req) begin
          if (read_hit) begin
            rdata_d = buf_data_q;
            state_d = DONE;
          end else begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_write;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d    = mem_rdata;
            buf_addr_d = mem_addr_q;
            buf_data_d = mem_rdata;
            valid_d    = 1'b1;
          end else if (valid_q && (buf_addr_q == mem_addr_q)) begin
            buf_data_d = mem_wdata_q;
          end
          state_d = DONE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_busy  = ((state_q == IDLE) && cpu_req) || (state_q == REQ);
  assign cpu_done  = (state_q == DONE);
  assign cpu_err   = (state_q == DONE) && err_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit with a short timeout. A behavioural model
// tracks the last-read buffer and predicts latency, request length, error
// and read data for each access, covering directed cases and random traffic.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_busy;
  logic          cpu_done;
  logic          cpu_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  bit            mValid = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mData = '0;
  logic [DW-1:0] mRdata = '0;

  mem_access_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access. The memory acks w cycles after the first mem_req
  // cycle (w > TO means it never acks). Expectations come from the model.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input bit rd, input bit wr, input int w,
                               input logic [DW-1:0] rdv);
    bit   isWrite;
    bit   hit;
    int   expLat;
    int   expReq;
    bit   expErr;
    int   n;
    int   reqCycles;
    int   doneAt;
    bit   firstReq;
    bit   errEarly;
    logic errSeen;
    logic [DW-1:0] rdSeen;

    isWrite = wr;
    hit     = !isWrite && mValid && (mAddr == a);
    if (hit) begin
      expLat = 1; expReq = 0; expErr = 1'b0;
      mRdata = mData;
    end else if (w <= TO) begin
      expLat = 2 + w; expReq = w + 1; expErr = 1'b0;
      if (!isWrite) begin
        mRdata = rdv; mValid = 1'b1; mAddr = a; mData = rdv;
      end else if (mValid && (mAddr == a)) begin
        mData = wd;
      end
    end else begin
      expLat = TO + 2; expReq = TO + 1; expErr = 1'b1;
    end

    @(negedge clk);
    cpu_addr = a; cpu_wdata = wd; cpu_read = rd; cpu_write = wr;
    #1;
    checkOutput("busy_on_request", cpu_busy, 1);

    n = 0; reqCycles = 0; doneAt = 0; firstReq = 1'b1; errEarly = 1'b0;
    errSeen = 1'b0; rdSeen = '0;
    while (doneAt == 0 && n < 60) begin
      @(negedge clk);
      n++;
      mem_ack   = 1'b0;
      mem_rdata = DW'($urandom);
      if (cpu_err && !cpu_done) errEarly = 1'b1;
      if (mem_req) begin
        reqCycles++;
        if (firstReq) begin
          firstReq = 1'b0;
          checkOutput("mem_addr", mem_addr, a);
          checkOutput("mem_we", mem_we, isWrite);
          if (isWrite) checkOutput("mem_wdata", mem_wdata, wd);
        end
        if (n == w + 1) begin
          mem_ack = 1'b1; mem_rdata = rdv;
        end
      end
      if (cpu_done) begin
        doneAt = n; errSeen = cpu_err; rdSeen = cpu_rdata;
      end
    end
    mem_ack = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0;

    checkOutput("done_within_budget", doneAt != 0, 1);
    checkOutput("latency", doneAt, expLat);
    checkOutput("req_cycles", reqCycles, expReq);
    checkOutput("err_pulse", errSeen, expErr);
    checkOutput("err_outside_done", errEarly, 0);
    checkOutput("rdata", rdSeen, mRdata);

    @(negedge clk);
    checkOutput("done_one_cycle", cpu_done, 0);
    checkOutput("idle_busy", cpu_busy, 0);
    checkOutput("idle_req", mem_req, 0);
  endtask

  // An ack with no access outstanding must not disturb anything.
  task automatic strayAck();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_ack_done", cpu_done, 0);
    checkOutput("stray_ack_req", mem_req, 0);
    checkOutput("stray_ack_rdata", cpu_rdata, mRdata);
  endtask

  initial begin
    int kind;
    int sel;
    logic [AW-1:0] ra;

    // Reset state
    #1;
    checkOutput("reset_rdata", cpu_rdata, 0);
    checkOutput("reset_busy", cpu_busy, 0);
    checkOutput("reset_done", cpu_done, 0);
    checkOutput("reset_err", cpu_err, 0);
    checkOutput("reset_req", mem_req, 0);
    checkOutput("reset_we", mem_we, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a write request, then a late ack
    @(negedge clk);
    cpu_addr = 13'h123; cpu_wdata = 8'h99; cpu_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_req", mem_req, 1);
    #2;
    rst = 1'b0; cpu_write = 1'b0;
    #1;
    checkOutput("midreset_req", mem_req, 0);
    checkOutput("midreset_we", mem_we, 0);
    checkOutput("midreset_addr", mem_addr, 0);
    checkOutput("midreset_wdata", mem_wdata, 0);
    checkOutput("midreset_busy", cpu_busy, 0);
    checkOutput("midreset_done", cpu_done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'hD1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("late_ack_done", cpu_done, 0);
    @(negedge clk);
    checkOutput("late_ack_req", mem_req, 0);
    checkOutput("late_ack_rdata", cpu_rdata, 0);

    // Directed accesses
    applyStimulus(13'h0A5, 8'h00, 1'b1, 1'b0, 3, 8'h3C);
    applyStimulus(13'h0A5, 8'h00, 1'b1, 1'b0, 3, 8'hC3);
    applyStimulus(13'h0A5, 8'h77, 1'b0, 1'b1, 1, 8'h00);
    applyStimulus(13'h0A5, 8'h00, 1'b1, 1'b0, 2, 8'h11);
    applyStimulus(13'h100, 8'h00, 1'b1, 1'b0, 99, 8'h42);
    strayAck();
    applyStimulus(13'h001, 8'h5A, 1'b1, 1'b1, TO, 8'h00);
    applyStimulus(13'h0A5, 8'h00, 1'b1, 1'b0, 0, 8'h22);
    applyStimulus(13'h002, 8'h00, 1'b1, 1'b0, 0, 8'h81);

    // Random traffic over a small address pool to exercise hits and timeouts
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ra = 13'h0A5;
        1:       ra = 13'h001;
        2:       ra = 13'h100;
        default: ra = AW'($urandom);
      endcase
      kind = $urandom_range(0, 3);
      applyStimulus(ra, DW'($urandom), kind != 2, kind >= 2,
                    $urandom_range(0, TO + 2), DW'($urandom));
      if ($urandom_range(0, 4) == 0) strayAck();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
